sha1_padder: RTL and testbench

// - Upstream of sha1_core. Packs a 32-bit big-endian message word stream into 512-bit blocks.
// - Applies SHA-1 padding: a 0x80 byte after the last message byte, zero fill, then the 64-bit bit length.
// - Emits blocks over a valid/ready handshake with a last-block flag, so the controller can sequence the

---
 rtl/sha1_padder.sv | 171 +++++++++++++++++
 tb/tb_sha1_padder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks, appends the 0x80
// marker, zero fill and 64-bit bit length, and hands blocks out over a valid/ready handshake.
module sha1_padder #(
    parameter int unsigned BlockWidth = 512,
    parameter int unsigned LenWidth   = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic [31:0]           data_i,
    input  logic [2:0]            data_bytes_i,
    input  logic                  data_last_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_last_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i
);

    localparam int unsigned Bytes = BlockWidth / 8;
    localparam int unsigned Words = BlockWidth / 32;

    typedef enum logic [1:0] {StFill, StEmit, StExtra} state_e;

    state_e                state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [BlockWidth-1:0] block_q, block_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic                  xpend_q, xpend_d;
    logic                  xmark_q, xmark_d;

    logic                  accept;
    logic [LenWidth-1:0]   len_add;
    logic [6:0]            m;
    logic [BlockWidth-1:0] blk_w, blk_pad, blk_extra;

    // Next-state logic: word packing, padding of the final block, extra block sequencing.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        len_d     = len_q;
        block_d   = block_q;
        last_d    = last_q;
        valid_d   = valid_q;
        xpend_d   = xpend_q;
        xmark_d   = xmark_q;

        data_ready_o = (state_q == StFill) & ~clear_i;
        accept       = data_valid_i & data_ready_o;
        len_add      = len_q + {{(LenWidth-6){1'b0}}, data_bytes_i, 3'b000};
        // Message bytes held in this block once the current word lands (0..64).
        m            = {1'b0, wcnt_q, 2'b00} + {4'b0000, data_bytes_i};

        blk_w = block_q;
        blk_w[(Words - 1 - int'(wcnt_q)) * 32 +: 32] = data_i;

        // Zero everything from byte m onward (also drops stale bytes of a previous block).
        blk_pad = blk_w;
        for (int i = 0; i < int'(Bytes); i++) begin
            if (7'(i) >= m) begin
                blk_pad[BlockWidth - 1 - 8 * i -: 8] = (7'(i) == m) ? 8'h80 : 8'h00;
            end
        end
        if (m <= 7'(Bytes - 9)) begin
            blk_pad[LenWidth-1:0] = len_add;
        end

        blk_extra = '0;
        blk_extra[BlockWidth-1 -: 8] = xmark_q ? 8'h80 : 8'h00;
        blk_extra[LenWidth-1:0] = len_q;

        case (state_q)
            StFill: begin
                if (accept) begin
                    len_d   = len_add;
                    if (!data_last_i) begin
                        block_d = blk_w;
                        if (wcnt_q == 4'd15) begin
                            state_d = StEmit;
                            valid_d = 1'b1;
                            last_d  = 1'b0;
                            xpend_d = 1'b0;
                            wcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + 4'd1;
                        end
                    end else begin
                        block_d = blk_pad;
                        state_d = StEmit;
                        valid_d = 1'b1;
                        wcnt_d  = '0;
                        if (m <= 7'(Bytes - 9)) begin
                            last_d  = 1'b1;
                            xpend_d = 1'b0;
                        end else begin
                            last_d  = 1'b0;
                            xpend_d = 1'b1;
                            xmark_d = (m == 7'(Bytes));
                        end
                    end
                end
            end
            StEmit: begin
                if (block_ready_i) begin
                    if (xpend_q) begin
                        block_d = blk_extra;
                        last_d  = 1'b1;
                        xpend_d = 1'b0;
                        state_d = StExtra;
                    end else begin
                        valid_d = 1'b0;
                        state_d = StFill;
                        if (last_q) begin
                            len_d  = '0;
                            wcnt_d = '0;
                        end
                    end
                end
            end
            StExtra: begin
                if (block_ready_i) begin
                    valid_d = 1'b0;
                    len_d   = '0;
                    wcnt_d  = '0;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase

        // Abort overrides everything; the block contents themselves are left alone.
        if (clear_i) begin
            state_d = StFill;
            wcnt_d  = '0;
            len_d   = '0;
            valid_d = 1'b0;
            xpend_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StFill;
            wcnt_q  <= '0;
            len_q   <= '0;
            block_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            xpend_q <= 1'b0;
            xmark_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            len_q   <= len_d;
            block_q <= block_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            xpend_q <= xpend_d;
            xmark_q <= xmark_d;
        end
    end

    assign block_o       = block_q;
    assign block_last_o  = last_q;
    assign block_valid_o = valid_q;

endmodule

// File: tb/tb_sha1_padder.sv
// Self-checking bench for sha1_padder: random messages against a byte-level SHA-1 padding model.
module tb_sha1_padder;

    typedef byte unsigned bq_t[$];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_i;
    logic [31:0]  data_i;
    logic [2:0]   data_bytes_i;
    logic         data_last_i;
    logic         data_valid_i;
    logic         data_ready_o;
    logic [511:0] block_o;
    logic         block_last_o;
    logic         block_valid_o;
    logic         block_ready_i;

    int tests  = 0;
    int failed = 0;

    logic [511:0] exp_blk_q[$];
    logic         exp_last_q[$];
    int           stall_left = 0;

    sha1_padder #(
        .BlockWidth(512),
        .LenWidth  (64)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear_i),
        .data_i       (data_i),
        .data_bytes_i (data_bytes_i),
        .data_last_i  (data_last_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .block_o      (block_o),
        .block_last_o (block_last_o),
        .block_valid_o(block_valid_o),
        .block_ready_i(block_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Standard SHA-1 padding on a byte array, split into 64-byte blocks.
    function automatic void model(input bq_t msg);
        bq_t             p;
        longint unsigned bits;
        int              nb;
        logic [511:0]    blk;
        p    = msg;
        bits = longint'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk[511 - 8*i -: 8] = p[64*b + i];
            exp_blk_q.push_back(blk);
            exp_last_q.push_back(b == nb - 1);
        end
    endfunction

    function automatic bq_t rand_msg(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic drive_word(input logic [31:0] w, input logic [2:0] nb, input logic last);
        int t = 0;
        data_i       = w;
        data_bytes_i = nb;
        data_last_i  = last;
        data_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (data_ready_o) break;
            t++;
            if (t > 2000) begin
                check_eq("word_accept_timeout", 512'(data_ready_o), 512'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
    endtask

    // Garbage in the unused low bytes checks that they are discarded.
    task automatic send_msg(input bq_t msg, input bit empty_tail, input int gap);
        int          n   = msg.size();
        int          idx = 0;
        int          nb;
        logic [31:0] w;
        while ((n - idx > 4) || (n - idx == 4 && empty_tail)) begin
            repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
            w = {msg[idx], msg[idx+1], msg[idx+2], msg[idx+3]};
            drive_word(w, 3'd4, 1'b0);
            idx += 4;
        end
        nb = n - idx;
        w  = $urandom;
        for (int k = 0; k < nb; k++) w[31 - 8*k -: 8] = msg[idx + k];
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        drive_word(w, 3'(nb), 1'b1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_blk_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) check_eq("drain_timeout", 512'(exp_blk_q.size()), 512'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("idle_after_msg", 512'(block_valid_o), 512'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input bq_t msg, input bit empty_tail, input int gap);
        model(msg);
        send_msg(msg, empty_tail, gap);
        wait_drain();
    endtask

    // Consumer: random ready, compares each handshaken block and checks stalls hold output.
    initial begin : monitor
        logic         prev_stall = 1'b0;
        logic [511:0] prev_blk   = '0;
        logic         prev_last  = 1'b0;
        block_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (block_valid_o && stall_left > 0) begin
                block_ready_i = 1'b0;
                stall_left--;
            end else begin
                block_ready_i = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (rst_n && block_valid_o) begin
                check_eq("data_ready_while_emit", 512'(data_ready_o), 512'(0));
                if (prev_stall) begin
                    check_eq("stall_block_stable", block_o, prev_blk);
                    check_eq("stall_last_stable", 512'(block_last_o), 512'(prev_last));
                end
                if (block_ready_i) begin
                    if (exp_blk_q.size() == 0) begin
                        check_eq("unexpected_block", 512'(1), 512'(0));
                    end else begin
                        check_eq("block", block_o, exp_blk_q.pop_front());
                        check_eq("block_last", 512'(block_last_o), 512'(exp_last_q.pop_front()));
                    end
                end
                prev_stall = !block_ready_i;
                prev_blk   = block_o;
                prev_last  = block_last_o;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bq_t msg;
        rst_n        = 1'b0;
        clear_i      = 1'b0;
        data_i       = '0;
        data_bytes_i = '0;
        data_last_i  = 1'b0;
        data_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_block", block_o, '0);
        check_eq("reset_valid", 512'(block_valid_o), 512'(0));
        check_eq("reset_last", 512'(block_last_o), 512'(0));
        check_eq("reset_ready", 512'(data_ready_o), 512'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // "abc"
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 1'b0, 0);
        // Empty message
        msg = '{};
        run_msg(msg, 1'b0, 0);
        // Padding boundaries
        run_msg(rand_msg(55), 1'b0, 1);
        run_msg(rand_msg(56), 1'b0, 1);
        run_msg(rand_msg(63), 1'b0, 0);
        run_msg(rand_msg(64), 1'b0, 0);
        run_msg(rand_msg(64), 1'b1, 0);
        run_msg(rand_msg(120), 1'b0, 2);

        // Backpressure: hold ready low 5 cycles on the first block
        stall_left = 5;
        run_msg(rand_msg(100), 1'b0, 0);

        // Abort after 8 words, with a valid word offered during the clear cycle
        for (int i = 0; i < 8; i++) drive_word($urandom, 3'd4, 1'b0);
        clear_i      = 1'b1;
        data_i       = $urandom;
        data_bytes_i = 3'd4;
        data_last_i  = 1'b0;
        data_valid_i = 1'b1;
        @(negedge clk);
        check_eq("ready_during_clear", 512'(data_ready_o), 512'(0));
        @(posedge clk);
        #1;
        clear_i      = 1'b0;
        data_valid_i = 1'b0;
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 1'b0, 0);

        // Asynchronous reset mid-block
        for (int i = 0; i < 5; i++) drive_word($urandom, 3'd4, 1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("midreset_block", block_o, '0);
        check_eq("midreset_valid", 512'(block_valid_o), 512'(0));
        check_eq("midreset_ready", 512'(data_ready_o), 512'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        run_msg(msg, 1'b0, 0);

        // Random messages
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 4) == 0) stall_left = $urandom_range(1, 6);
            run_msg(rand_msg($urandom_range(0, 200)), 1'($urandom_range(0, 1)), 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
